// File: rtl/alu_pkg.sv
// Shared definitions for the ALU slice sequencer.
//   - select-field constants (operand modifier s[1:0], operation s[3:2])
//   - FSM state encoding
//   - SLICE_W: bits processed per clock
//   - mod_b(): applies the operand modifier to one slice of B
package alu_pkg;

  localparam int SLICE_W = 4;

  // s[1:0]: operand modifier producing b'
  localparam logic [1:0] OPM_B    = 2'b00;
  localparam logic [1:0] OPM_NB   = 2'b01;
  localparam logic [1:0] OPM_ZERO = 2'b10;
  localparam logic [1:0] OPM_ONES = 2'b11;

  // s[3:2]: operation
  localparam logic [1:0] OP_ARITH = 2'b00;
  localparam logic [1:0] OP_AND   = 2'b01;
  localparam logic [1:0] OP_OR    = 2'b10;
  localparam logic [1:0] OP_XOR   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Captured select code, split into its two fields
  typedef struct packed {
    logic [1:0] op;
    logic [1:0] opm;
  } sel_t;

  function automatic logic [SLICE_W-1:0] mod_b(input logic [SLICE_W-1:0] b,
                                               input logic [1:0]         opm);
    case (opm)
      OPM_B:    mod_b = b;
      OPM_NB:   mod_b = ~b;
      OPM_ZERO: mod_b = '0;
      default:  mod_b = '1;
    endcase
  endfunction

endpackage

// File: rtl/cla_slice.sv
// 4-bit carry-lookahead slice (purely combinational).
//   p, g   : per-bit propagate / generate
//   c_in   : carry into bit 0 of the slice
//   sum    : p ^ carry for each bit
//   c_out  : group carry-out, from group G/P (two-level lookahead)
module cla_slice
  import alu_pkg::*;
(
  input  logic [SLICE_W-1:0] p,
  input  logic [SLICE_W-1:0] g,
  input  logic               c_in,
  output logic [SLICE_W-1:0] sum,
  output logic               c_out
);

  logic [SLICE_W-1:0] c;
  logic               grp_g;
  logic               grp_p;

  // First level: every internal carry directly from p/g and c_in
  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_in);

  // Second level: group generate/propagate feed the carry-out
  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);
  assign grp_p = &p;
  assign c_out = grp_g | (grp_p & c_in);

  assign sum = p ^ c;

endmodule

// File: rtl/alu_slice_sequencer.sv
// Multi-cycle ALU back end: processes one 4-bit slice per clock.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b, s, cin)
//   out_valid / out_ready: result handshake (result, cout, zero)
// Operands are captured on acceptance, slices 0..NSLICE-1 are resolved
// through one shared cla_slice with the group carry held in carry_q,
// and the result is held in DONE until the consumer takes it.
module alu_slice_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16  // multiple of 4, >= 4
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  sel_t               sel_q;
  logic [KW-1:0]      k_q;
  logic               carry_q;
  logic [WIDTH-1:0]   result_q;
  logic               cout_q, zero_q;

  logic               accept;
  logic               last;
  int unsigned        base;
  logic [SLICE_W-1:0] a_sl, b_sl, p_sl, g_sl, sum_sl, res_sl;
  logic               c_out_sl;
  logic [WIDTH-1:0]   res_merged;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last)      state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: in_ready  = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept = in_valid && (state_q == ST_IDLE);
  assign last   = (state_q == ST_RUN) && (k_q == KW'(NSLICE - 1));

  // ---------------- slice datapath ----------------
  always_comb begin
    base = 32'(k_q) * SLICE_W;
    a_sl = a_q[base +: SLICE_W];
    b_sl = mod_b(b_q[base +: SLICE_W], sel_q.opm);
    p_sl = a_sl ^ b_sl;
    g_sl = a_sl & b_sl;
  end

  cla_slice u_cla (
    .p     (p_sl),
    .g     (g_sl),
    .c_in  (carry_q),
    .sum   (sum_sl),
    .c_out (c_out_sl)
  );

  always_comb begin
    case (sel_q.op)
      OP_ARITH: res_sl = sum_sl;
      OP_AND:   res_sl = g_sl;          // a & b'
      OP_OR:    res_sl = a_sl | b_sl;
      default:  res_sl = p_sl;          // a ^ b'
    endcase
    // Lower slices already hold this operation's bits, so on the last
    // slice res_merged is the complete result and feeds the zero flag.
    res_merged = result_q;
    res_merged[base +: SLICE_W] = res_sl;
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      k_q      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      sel_q   <= sel_t'(s);
      k_q     <= '0;
      carry_q <= cin;
    end else if (state_q == ST_RUN) begin
      result_q <= res_merged;
      carry_q  <= c_out_sl;
      if (last) begin
        k_q    <= '0;
        cout_q <= (sel_q.op == OP_ARITH) ? c_out_sl : 1'b0;
        zero_q <= (res_merged == '0);
      end else begin
        k_q <= k_q + KW'(1);
      end
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_slice_sequencer.sv
module tb_alu_slice_sequencer;
  localparam int W  = 16;
  localparam int NS = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic [3:0]   s = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         cout, zero;

  int n_cmp = 0;
  int n_bad = 0;

  alu_slice_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .s(s), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .cout(cout), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic, carry is bit W of the sum.
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic [3:0] ms, input logic mc);
    logic [W-1:0] bm;
    case (ms[1:0])
      2'b00:   bm = mb;
      2'b01:   bm = ~mb;
      2'b10:   bm = '0;
      default: bm = '1;
    endcase
    case (ms[3:2])
      2'b00:   model = {1'b0, ma} + {1'b0, bm} + {{W{1'b0}}, mc};
      2'b01:   model = {1'b0, ma & bm};
      2'b10:   model = {1'b0, ma | bm};
      default: model = {1'b0, ma ^ bm};
    endcase
  endfunction

  // One complete transaction; hold = cycles out_ready is kept low in DONE,
  // during which inputs are scrambled and in_valid toggled.
  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic [3:0] ts, input logic tc, input int hold);
    logic [W:0]   exp;
    logic [W-1:0] exp_res;
    int n;
    exp     = model(ta, tb_, ts, tc);
    exp_res = exp[W-1:0];
    n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_; s = ts; cin = tc; in_valid = 1'b1;
    out_ready = (hold == 0);
    step();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); s = 4'($urandom); cin = 1'($urandom);
    n = 0;
    while (!out_valid && n < 3 * NS) begin step(); n++; end
    chk({tag, ".latency"}, 32'(n), 32'(NS));
    chk({tag, ".result"}, 32'(result), 32'(exp_res));
    chk({tag, ".cout"}, 32'(cout), 32'(exp[W]));
    chk({tag, ".zero"}, 32'(zero), 32'(exp_res == '0));
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      a = W'($urandom); b = W'($urandom);
      step();
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_result"}, 32'(result), 32'(exp_res));
      chk({tag, ".hold_cout"}, 32'(cout), 32'(exp[W]));
      chk({tag, ".hold_zero"}, 32'(zero), 32'(exp_res == '0));
      chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk({tag, ".exit_in_ready"}, 32'(in_ready), 32'd0);
    step();
    chk({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".idle_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".idle_result"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst.result", 32'(result), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.cout", 32'(cout), 32'd0);
    chk("rst.zero", 32'(zero), 32'd0);

    // Directed
    do_op("add",      16'h1234, 16'h0FCD, 4'b0000, 1'b0, 0);
    do_op("add_wrap", 16'hFFFF, 16'h0001, 4'b0000, 1'b0, 0);
    do_op("sub_neg",  16'h0005, 16'h0007, 4'b0001, 1'b1, 0);
    do_op("sub_pos",  16'h0007, 16'h0005, 4'b0001, 1'b1, 0);
    do_op("and",      16'hF0F0, 16'h3C3C, 4'b0100, 1'b0, 0);
    do_op("xor",      16'hAAAA, 16'hFFFF, 4'b1100, 1'b0, 0);
    do_op("or_ones",  16'h1357, 16'h0000, 4'b1011, 1'b1, 0);
    do_op("bp",       16'h8001, 16'h7FFF, 4'b0000, 1'b0, 3);

    // Reset mid-RUN at k = 2
    a = 16'h1111; b = 16'h2222; s = 4'b0000; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    #2;
    chk("mid_rst.result", 32'(result), 32'd0);
    chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst.cout", 32'(cout), 32'd0);
    chk("mid_rst.zero", 32'(zero), 32'd0);
    rst = 1'b0;
    step();
    chk("mid_rst.in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst.result2", 32'(result), 32'd0);
    do_op("post_rst", 16'h0001, 16'h0001, 4'b0000, 1'b0, 0);

    // Randomized against the model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 8 == 0) ra = '1;
      do_op("rand", ra, rb, 4'($urandom), 1'($urandom), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
